// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, shared 1 ms tick divider and a per-button
// debounce FSM producing clean levels, one-cycle press/release pulses and a both-pressed flag.
//   state        | meaning
//   RELEASED     | committed level 0, input agrees
//   PRESS_PEND   | committed level 0, counting ticks with input 1
//   PRESSED      | committed level 1, input agrees
//   RELEASE_PEND | committed level 1, counting ticks with input 0
module btn_debounce #(
    parameter int FREQ_OF_CLK_IN        = 100,
    parameter int MAX_CNT_WIDTH_DIVIDER = 32,
    parameter int DEBOUNCE_MS           = 10,
    parameter int NUM_BTN               = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic               both_pressed
);

    localparam int TICK_DIV = FREQ_OF_CLK_IN * 1000;
    localparam int STAB_W   = $clog2(DEBOUNCE_MS + 1);

    localparam logic [MAX_CNT_WIDTH_DIVIDER-1:0] DIV_LAST = MAX_CNT_WIDTH_DIVIDER'(TICK_DIV - 1);
    localparam logic [MAX_CNT_WIDTH_DIVIDER-1:0] DIV_ONE  = MAX_CNT_WIDTH_DIVIDER'(1);
    localparam logic [STAB_W-1:0]                STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0]                STAB_DONE = STAB_W'(DEBOUNCE_MS);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_t;

    logic [NUM_BTN-1:0]               r_sync1;
    logic [NUM_BTN-1:0]               r_sync2;
    logic [MAX_CNT_WIDTH_DIVIDER-1:0] r_div;
    logic                             w_tick;

    state_t                           r_state     [NUM_BTN];
    state_t                           w_state_nxt [NUM_BTN];
    logic [STAB_W-1:0]                r_stab      [NUM_BTN];
    logic [STAB_W-1:0]                w_stab_nxt  [NUM_BTN];
    logic [STAB_W-1:0]                w_stab_inc  [NUM_BTN];

    logic [NUM_BTN-1:0]               r_level;
    logic [NUM_BTN-1:0]               r_rise;
    logic [NUM_BTN-1:0]               r_fall;
    logic                             r_both;
    logic [NUM_BTN-1:0]               w_level_nxt;
    logic [NUM_BTN-1:0]               w_rise_nxt;
    logic [NUM_BTN-1:0]               w_fall_nxt;
    logic                             w_both_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

    // State register; the output flops live here too so they move on the committing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= ST_RELEASED;
                r_stab[i]  <= '0;
            end
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_both  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_stab[i]  <= w_stab_nxt[i];
            end
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_both  <= w_both_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_stab_nxt[i]  = r_stab[i];
            w_stab_inc[i]  = r_stab[i] + STAB_ONE;
            if (w_tick) begin
                case (r_state[i])
                    ST_RELEASED: begin
                        if (r_sync2[i]) begin
                            if (DEBOUNCE_MS == 1) begin
                                w_state_nxt[i] = ST_PRESSED;
                                w_stab_nxt[i]  = '0;
                            end else begin
                                w_state_nxt[i] = ST_PRESS_PEND;
                                w_stab_nxt[i]  = STAB_ONE;
                            end
                        end
                    end
                    ST_PRESS_PEND: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt[i] = ST_RELEASED;
                            w_stab_nxt[i]  = '0;
                        end else if (w_stab_inc[i] == STAB_DONE) begin
                            w_state_nxt[i] = ST_PRESSED;
                            w_stab_nxt[i]  = '0;
                        end else begin
                            w_stab_nxt[i]  = w_stab_inc[i];
                        end
                    end
                    ST_PRESSED: begin
                        if (!r_sync2[i]) begin
                            if (DEBOUNCE_MS == 1) begin
                                w_state_nxt[i] = ST_RELEASED;
                                w_stab_nxt[i]  = '0;
                            end else begin
                                w_state_nxt[i] = ST_RELEASE_PEND;
                                w_stab_nxt[i]  = STAB_ONE;
                            end
                        end
                    end
                    ST_RELEASE_PEND: begin
                        if (r_sync2[i]) begin
                            w_state_nxt[i] = ST_PRESSED;
                            w_stab_nxt[i]  = '0;
                        end else if (w_stab_inc[i] == STAB_DONE) begin
                            w_state_nxt[i] = ST_RELEASED;
                            w_stab_nxt[i]  = '0;
                        end else begin
                            w_stab_nxt[i]  = w_stab_inc[i];
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_RELEASED;
                        w_stab_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_level_nxt[i] = (w_state_nxt[i] == ST_PRESSED) ||
                             (w_state_nxt[i] == ST_RELEASE_PEND);
        end
        w_rise_nxt = w_level_nxt & ~r_level;
        w_fall_nxt = ~w_level_nxt & r_level;
        w_both_nxt = w_level_nxt[1] & w_level_nxt[0];
    end

    assign btn_level    = r_level;
    assign btn_rise     = r_rise;
    assign btn_fall     = r_fall;
    assign both_pressed = r_both;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: per-cycle run-length reference model, a table of tick-aligned
// hold segments, hand-written corner sequences and a randomized soak.
module tb_btn_debounce;

    localparam int FREQ     = 1;
    localparam int DB       = 3;
    localparam int NB       = 2;
    localparam int TICK_DIV = FREQ * 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_rise;
    logic [NB-1:0] btn_fall;
    logic          both_pressed;

    always #5 clk = ~clk;

    btn_debounce #(
        .FREQ_OF_CLK_IN        (FREQ),
        .MAX_CNT_WIDTH_DIVIDER (32),
        .DEBOUNCE_MS           (DB),
        .NUM_BTN               (NB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .btn_level    (btn_level),
        .btn_rise     (btn_rise),
        .btn_fall     (btn_fall),
        .both_pressed (both_pressed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: a level flips once DB consecutive tick samples disagree with it.
    logic [NB-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    int            m_div;
    int            m_run [NB];

    logic [NB-1:0] rise_or, fall_or;
    int            rise_cnt;

    typedef struct {
        logic [NB-1:0] btn;
        int            ticks;
        logic [NB-1:0] lvl;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_div = 0;
        for (int b = 0; b < NB; b++) m_run[b] = 0;
    endtask

    task automatic model_step();
        logic tick;
        tick   = (m_div == TICK_DIV - 1);
        m_rise = '0;
        m_fall = '0;
        if (tick) begin
            for (int b = 0; b < NB; b++) begin
                if (m_s2[b] != m_level[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_level[b] = ~m_level[b];
                        m_run[b]   = 0;
                        if (m_level[b]) m_rise[b] = 1'b1;
                        else            m_fall[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_div = tick ? 0 : m_div + 1;
        m_s2  = m_s1;
        m_s1  = btn;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        cyc_n++;
        check("model", 32'({btn_level, btn_rise, btn_fall, both_pressed}),
              32'({m_level, m_rise, m_fall, &m_level}));
        rise_or  = rise_or | btn_rise;
        fall_or  = fall_or | btn_fall;
        rise_cnt = rise_cnt + int'(btn_rise[0]) + int'(btn_rise[1]);
    endtask

    task automatic run_to(input int target);
        while (cyc_n < target) cyc();
    endtask

    task automatic clear_acc();
        rise_or  = '0;
        fall_or  = '0;
        rise_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", 32'({btn_level, btn_rise, btn_fall, both_pressed}), 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        rst_n = 1'b1;
        cyc_n = 0;
        clear_acc();
    endtask

    initial begin
        tbl[0]  = '{2'b00, 2, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, 3, 2'b01, 2'b01, 2'b00};
        tbl[2]  = '{2'b11, 2, 2'b01, 2'b00, 2'b00};
        tbl[3]  = '{2'b10, 1, 2'b11, 2'b10, 2'b00};
        tbl[4]  = '{2'b00, 2, 2'b10, 2'b00, 2'b01};
        tbl[5]  = '{2'b11, 4, 2'b11, 2'b01, 2'b00};
        tbl[6]  = '{2'b00, 3, 2'b00, 2'b00, 2'b11};
        tbl[7]  = '{2'b01, 2, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b00, 1, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{2'b01, 2, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b01, 1, 2'b01, 2'b01, 2'b00};

        model_reset();
        clear_acc();
        @(negedge clk);

        // Idle after reset
        btn = 2'b00;
        do_reset();
        run_to(5000);
        check("idle_level", 32'(btn_level), 32'd0);
        check("idle_rise", 32'(rise_or), 32'd0);
        check("idle_fall", 32'(fall_or), 32'd0);

        // Clean press on bit 0 from cycle 10
        do_reset();
        run_to(10);
        btn = 2'b01;
        run_to(2999);
        check("press_before", 32'(btn_level), 32'd0);
        run_to(3000);
        check("press_level", 32'(btn_level), 32'h1);
        check("press_rise", 32'(btn_rise), 32'h1);
        run_to(4000);
        check("press_rise_count", 32'(rise_cnt), 32'd1);
        check("press_no_fall", 32'(fall_or), 32'd0);

        // Bounce: high 2 ticks, low 1 tick, then high
        btn = 2'b00;
        do_reset();
        btn = 2'b01;
        run_to(2500);
        btn = 2'b00;
        run_to(3500);
        btn = 2'b01;
        run_to(5999);
        check("bounce_before", 32'(btn_level), 32'd0);
        check("bounce_no_rise", 32'(rise_cnt), 32'd0);
        run_to(6000);
        check("bounce_level", 32'(btn_level), 32'h1);
        check("bounce_rise", 32'(btn_rise), 32'h1);
        run_to(6100);
        check("bounce_rise_count", 32'(rise_cnt), 32'd1);

        // Both pressed, later level gates both_pressed; then release bit 1
        btn = 2'b00;
        do_reset();
        btn = 2'b01;
        run_to(1500);
        btn = 2'b11;
        run_to(3999);
        check("both_early_level", 32'(btn_level), 32'h1);
        check("both_early", 32'(both_pressed), 32'd0);
        run_to(4000);
        check("both_level", 32'(btn_level), 32'h3);
        check("both_set", 32'(both_pressed), 32'd1);
        check("both_rise1", 32'(btn_rise), 32'h2);
        run_to(4500);
        btn = 2'b01;
        run_to(6999);
        check("rel_before", 32'(both_pressed), 32'd1);
        run_to(7000);
        check("rel_fall1", 32'(btn_fall), 32'h2);
        check("rel_both", 32'(both_pressed), 32'd0);
        check("rel_level", 32'(btn_level), 32'h1);

        // Reset in the middle of a pending press discards the progress
        btn = 2'b00;
        do_reset();
        btn = 2'b10;
        run_to(1500);
        btn = 2'b11;
        run_to(3500);
        check("midrst_pre_level", 32'(btn_level), 32'h2);
        do_reset();
        run_to(2999);
        check("midrst_before", 32'(btn_level), 32'd0);
        run_to(3000);
        check("midrst_level", 32'(btn_level), 32'h3);
        check("midrst_rise", 32'(btn_rise), 32'h3);

        // Press on bit 0 and release on bit 1 committing on the same tick
        btn = 2'b00;
        do_reset();
        btn = 2'b10;
        run_to(3000);
        check("simul_pre", 32'(btn_level), 32'h2);
        run_to(3200);
        btn = 2'b01;
        run_to(5999);
        check("simul_before", 32'(btn_level), 32'h2);
        run_to(6000);
        check("simul_rise", 32'(btn_rise), 32'h1);
        check("simul_fall", 32'(btn_fall), 32'h2);
        run_to(6001);
        check("simul_pulse_end", 32'({btn_rise, btn_fall}), 32'd0);

        // Table of tick-aligned hold segments
        btn = 2'b00;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            btn = tbl[i].btn;
            clear_acc();
            run_to(cyc_n + tbl[i].ticks * TICK_DIV);
            check($sformatf("tbl%0d_level", i), 32'(btn_level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_rise", i), 32'(rise_or), 32'(tbl[i].rise));
            check($sformatf("tbl%0d_fall", i), 32'(fall_or), 32'(tbl[i].fall));
        end

        // Randomized soak against the model, with one random mid-run reset
        btn = 2'b00;
        do_reset();
        begin
            int rst_at;
            int stop_at;
            rst_at  = int'($urandom_range(6000, 12000));
            stop_at = 20000;
            while (cyc_n < stop_at) begin
                btn = 2'($urandom);
                run_to(cyc_n + int'($urandom_range(500, 4500)));
                if (rst_at > 0 && cyc_n >= rst_at) begin
                    rst_at  = 0;
                    stop_at = stop_at - cyc_n;
                    do_reset();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
